// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Included by the fetch FSM and its IF/ID queue.
package rv_fetch_pkg;

    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;

    localparam logic [6:0] HALT_OPCODE = 7'b1111111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DROP = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
        return instr[6:0] == HALT_OPCODE;
    endfunction

endpackage

// File: rtl/if_fetch_queue.sv
// Two-entry IF/ID FIFO holding fetched {pc, instr} pairs.
// Head is served straight from the storage registers.
module if_fetch_queue
    import rv_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  fetch_entry_t i_entry,
    input  logic         i_pop,
    input  logic         i_flush,
    output fetch_entry_t o_head,
    output logic [1:0]   o_count,
    output logic         o_full,
    output logic         o_empty
);

    fetch_entry_t r_mem [2];
    logic         r_rd_ptr;
    logic         r_wr_ptr;
    logic [1:0]   r_count;
    logic         w_push;
    logic         w_pop;

    assign w_push = i_push && (r_count != 2'd2);
    assign w_pop  = i_pop && (r_count != 2'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_entry;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == 2'd2);
    assign o_empty = (r_count == 2'd0);

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: one outstanding word read at a time,
// results buffered in a 2-entry IF/ID queue, with flush and halt.
module if_fetch_unit
    import rv_fetch_pkg::*;
#(
    parameter int pc_width    = PC_W,
    parameter int instr_width = INSTR_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [pc_width-1:0]    pc_in,
    output logic                   pc_advance,
    output logic                   imem_req,
    output logic [pc_width-1:0]    imem_addr,
    input  logic                   imem_ready,
    input  logic                   imem_rvalid,
    input  logic [instr_width-1:0] imem_rdata,
    output logic                   id_valid,
    input  logic                   id_ready,
    output logic [pc_width-1:0]    id_pc,
    output logic [instr_width-1:0] id_instr,
    output logic [6:0]             id_opcode,
    input  logic                   flush,
    output logic                   fetch_halted
);

    fetch_state_t        r_state;
    fetch_state_t        w_next;
    logic [pc_width-1:0] r_addr;
    logic                r_halted;
    logic                w_issue;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic                w_in_flight;
    logic [1:0]          w_count;
    logic [2:0]          w_occupancy;
    fetch_entry_t        w_push_entry;
    fetch_entry_t        w_head;

    assign w_in_flight = (r_state != S_IDLE);
    assign w_occupancy = {1'b0, w_count} + {2'b00, w_in_flight};
    assign w_issue     = (r_state == S_IDLE) && !flush && !r_halted
                         && !w_full && (w_occupancy < 3'd2);

    // A response landing in a flush cycle is discarded, never queued.
    assign w_push = (r_state == S_WAIT) && imem_rvalid && !flush;
    assign w_pop  = !w_empty && id_ready;

    assign w_push_entry.pc    = PC_W'(r_addr);
    assign w_push_entry.instr = INSTR_W'(imem_rdata);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        imem_req   = 1'b0;
        pc_advance = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_issue) begin
                    w_next = S_REQ;
                end
            end
            S_REQ: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    pc_advance = 1'b1;
                    w_next     = flush ? S_DROP : S_WAIT;
                end else if (flush) begin
                    w_next = S_IDLE;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    w_next = S_IDLE;
                end else if (flush) begin
                    w_next = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_rvalid) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= '0;
        end else if (w_issue) begin
            r_addr <= pc_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_halted <= 1'b0;
        end else if (flush) begin
            r_halted <= 1'b0;
        end else if (w_push && is_halt(w_push_entry.instr)) begin
            r_halted <= 1'b1;
        end
    end

    if_fetch_queue u_queue (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_entry (w_push_entry),
        .i_pop   (w_pop),
        .i_flush (flush),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign imem_addr    = r_addr;
    assign id_valid     = !w_empty;
    assign id_pc        = pc_width'(w_head.pc);
    assign id_instr     = instr_width'(w_head.instr);
    assign id_opcode    = id_instr[6:0];
    assign fetch_halted = r_halted;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed testbench for if_fetch_unit with a variable-latency
// instruction memory model and a stepping PC register.
module tb_if_fetch_unit;
    import rv_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic        pc_advance;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [6:0]  id_opcode;
    logic        flush;
    logic        fetch_halted;

    int          checks = 0;
    int          errors = 0;
    int          mem_lat;
    logic [31:0] halt_addr;
    logic [31:0] pc_base;
    int          pc_steps = 0;
    logic        pend = 1'b0;
    int          pend_cnt = 0;
    logic [31:0] pend_data = 32'h0;

    if_fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .pc_in        (pc_in),
        .pc_advance   (pc_advance),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .id_valid     (id_valid),
        .id_ready     (id_ready),
        .id_pc        (id_pc),
        .id_instr     (id_instr),
        .id_opcode    (id_opcode),
        .flush        (flush),
        .fetch_halted (fetch_halted)
    );

    always #5 clk = ~clk;

    assign pc_in = pc_base + 32'(pc_steps) * 32'd4;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        if (a == halt_addr) return 32'h0000007F;
        return {a[19:0], 12'h013};
    endfunction

    // Memory responder and PC register, updated just after each rising edge.
    always @(posedge clk) begin
        logic        acc;
        logic        adv;
        logic [31:0] a;
        acc = imem_req && imem_ready;
        adv = pc_advance;
        a   = imem_addr;
        #1;
        if (rst) begin
            pend        = 1'b0;
            imem_rvalid = 1'b0;
            pc_steps    = 0;
        end else begin
            imem_rvalid = 1'b0;
            if (pend) begin
                pend_cnt = pend_cnt - 1;
                if (pend_cnt <= 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = pend_data;
                    pend        = 1'b0;
                end
            end
            if (acc) begin
                if (mem_lat <= 1) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = instr_of(a);
                end else begin
                    pend      = 1'b1;
                    pend_cnt  = mem_lat - 1;
                    pend_data = instr_of(a);
                end
            end
            if (adv) pc_steps = pc_steps + 1;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        flush      = 1'b0;
        id_ready   = 1'b0;
        imem_ready = 1'b1;
        mem_lat    = 1;
        halt_addr  = 32'hFFFF_FFF0;
        pc_base    = 32'h0;
        tick();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        flush      = 1'b0;
        id_ready   = 1'b0;
        imem_ready = 1'b1;
        mem_lat    = 1;
        halt_addr  = 32'hFFFF_FFF0;
        pc_base    = 32'h0;
        tick();
        tick();
        checks++;
        if (imem_req !== 1'b0) begin
            errors++; $display("FAIL reset_imem_req: got %b want 0", imem_req);
        end
        checks++;
        if (imem_addr !== 32'h0) begin
            errors++; $display("FAIL reset_imem_addr: got %h want 0", imem_addr);
        end
        checks++;
        if (pc_advance !== 1'b0) begin
            errors++; $display("FAIL reset_pc_advance: got %b want 0", pc_advance);
        end
        checks++;
        if (id_valid !== 1'b0) begin
            errors++; $display("FAIL reset_id_valid: got %b want 0", id_valid);
        end
        checks++;
        if (id_pc !== 32'h0 || id_instr !== 32'h0) begin
            errors++; $display("FAIL reset_id_data: got pc %h instr %h want 0 0", id_pc, id_instr);
        end
        checks++;
        if (fetch_halted !== 1'b0) begin
            errors++; $display("FAIL reset_halted: got %b want 0", fetch_halted);
        end
    endtask

    task automatic test_first_fetch();
        do_reset();
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || pc_advance !== 1'b1) begin
            errors++;
            $display("FAIL first_req: got req %b addr %h adv %b want 1 0 1",
                     imem_req, imem_addr, pc_advance);
        end
        tick();
        checks++;
        if (pc_advance !== 1'b0 || id_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_wait: got adv %b id_valid %b want 0 0", pc_advance, id_valid);
        end
        tick();
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== 32'h13) begin
            errors++;
            $display("FAIL first_data: got v %b pc %h instr %h want 1 0 13",
                     id_valid, id_pc, id_instr);
        end
    endtask

    task automatic test_backpressure();
        int acc = 0;
        int n = 0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            tick();
            if (pc_advance) acc++;
        end
        checks++;
        if (acc != 2 || imem_req !== 1'b0) begin
            errors++; $display("FAIL bp_accepts: got %0d req %b want 2 0", acc, imem_req);
        end
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h0) begin
            errors++; $display("FAIL bp_head0: got v %b pc %h want 1 0", id_valid, id_pc);
        end
        id_ready = 1'b1;
        tick();
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h4 || id_instr !== 32'h00004013) begin
            errors++;
            $display("FAIL bp_head4: got v %b pc %h instr %h want 1 4 00004013",
                     id_valid, id_pc, id_instr);
        end
        tick();
        checks++;
        if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h8) begin
            errors++;
            $display("FAIL bp_refetch: got v %b req %b addr %h want 0 1 8",
                     id_valid, imem_req, imem_addr);
        end
        while (!id_valid && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h8) begin
            errors++; $display("FAIL bp_head8: got v %b pc %h want 1 8", id_valid, id_pc);
        end
    endtask

    task automatic test_stall();
        int n = 0;
        do_reset();
        imem_ready = 1'b0;
        id_ready   = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h0 || pc_advance !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d: got req %b addr %h adv %b want 1 0 0",
                         i, imem_req, imem_addr, pc_advance);
            end
        end
        imem_ready = 1'b1;
        #1;
        checks++;
        if (pc_advance !== 1'b1) begin
            errors++; $display("FAIL stall_accept: got adv %b want 1", pc_advance);
        end
        tick();
        checks++;
        if (imem_req !== 1'b0 || pc_advance !== 1'b0) begin
            errors++;
            $display("FAIL stall_wait: got req %b adv %b want 0 0", imem_req, pc_advance);
        end
        while (!id_valid && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h0) begin
            errors++; $display("FAIL stall_data: got v %b pc %h want 1 0", id_valid, id_pc);
        end
    endtask

    task automatic test_flush_wait();
        int n = 0;
        do_reset();
        id_ready = 1'b1;
        mem_lat  = 3;
        tick();
        tick();
        flush   = 1'b1;
        pc_base = 32'h100 - 32'(pc_steps) * 32'd4;
        tick();
        flush = 1'b0;
        checks++;
        if (dut.r_state !== S_DROP || id_valid !== 1'b0) begin
            errors++;
            $display("FAIL fw_drop: got state %0d v %b want %0d 0", dut.r_state, id_valid, S_DROP);
        end
        tick();
        tick();
        checks++;
        if (id_valid !== 1'b0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL fw_discard: got v %b req %b want 0 0", id_valid, imem_req);
        end
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            errors++;
            $display("FAIL fw_newreq: got req %b addr %h want 1 100", imem_req, imem_addr);
        end
        while (!id_valid && n < 12) begin
            tick();
            n++;
        end
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h100 || id_instr !== 32'h00100013) begin
            errors++;
            $display("FAIL fw_data: got v %b pc %h instr %h want 1 100 00100013",
                     id_valid, id_pc, id_instr);
        end
    endtask

    task automatic test_flush_req_ready();
        int n = 0;
        do_reset();
        id_ready   = 1'b1;
        imem_ready = 1'b0;
        tick();
        flush      = 1'b1;
        imem_ready = 1'b1;
        #1;
        checks++;
        if (pc_advance !== 1'b1) begin
            errors++; $display("FAIL frr_adv: got %b want 1", pc_advance);
        end
        tick();
        flush = 1'b0;
        checks++;
        if (dut.r_state !== S_DROP) begin
            errors++; $display("FAIL frr_drop: got state %0d want %0d", dut.r_state, S_DROP);
        end
        tick();
        checks++;
        if (id_valid !== 1'b0 || dut.r_state !== S_IDLE) begin
            errors++;
            $display("FAIL frr_discard: got v %b state %0d want 0 %0d", id_valid, dut.r_state, S_IDLE);
        end
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
            errors++;
            $display("FAIL frr_next: got req %b addr %h want 1 4", imem_req, imem_addr);
        end
        while (!id_valid && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h4) begin
            errors++; $display("FAIL frr_data: got v %b pc %h want 1 4", id_valid, id_pc);
        end
    endtask

    task automatic test_halt();
        int reqs = 0;
        int n = 0;
        do_reset();
        halt_addr = 32'h0;
        tick();
        tick();
        tick();
        checks++;
        if (fetch_halted !== 1'b1 || id_valid !== 1'b1 || id_opcode !== 7'h7F
            || id_instr !== 32'h7F) begin
            errors++;
            $display("FAIL halt_set: got h %b v %b op %h instr %h want 1 1 7f 0000007f",
                     fetch_halted, id_valid, id_opcode, id_instr);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            if (imem_req) reqs++;
        end
        checks++;
        if (reqs != 0 || fetch_halted !== 1'b1) begin
            errors++;
            $display("FAIL halt_stop: got %0d req cycles halted %b want 0 1", reqs, fetch_halted);
        end
        flush   = 1'b1;
        pc_base = 32'h40 - 32'(pc_steps) * 32'd4;
        tick();
        flush = 1'b0;
        checks++;
        if (fetch_halted !== 1'b0 || id_valid !== 1'b0) begin
            errors++;
            $display("FAIL halt_flush: got h %b v %b want 0 0", fetch_halted, id_valid);
        end
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
            errors++;
            $display("FAIL halt_resume: got req %b addr %h want 1 40", imem_req, imem_addr);
        end
        while (!id_valid && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h40 || fetch_halted !== 1'b0) begin
            errors++;
            $display("FAIL halt_data: got v %b pc %h h %b want 1 40 0",
                     id_valid, id_pc, fetch_halted);
        end
    endtask

    task automatic test_back_to_back();
        int          acc = 0;
        int          seen = 0;
        logic [31:0] pcs [4];
        do_reset();
        id_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (pc_advance) acc++;
            if (id_valid && seen < 4) begin
                pcs[seen] = id_pc;
                seen++;
            end
        end
        checks++;
        if (acc != 4 || seen != 4) begin
            errors++;
            $display("FAIL b2b_rate: got %0d accepts %0d pops want 4 4", acc, seen);
        end
        for (int i = 0; i < seen; i++) begin
            checks++;
            if (pcs[i] !== 32'(i * 4)) begin
                errors++;
                $display("FAIL b2b_order%0d: got %h want %h", i, pcs[i], 32'(i * 4));
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_backpressure();
        test_stall();
        test_flush_wait();
        test_flush_req_ready();
        test_halt();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
